// File: rtl/cfa_pkg.sv
// Shared widths for the entry-wise statistics path (accumulator and mean).
// Pure constants and one helper; no logic of its own.
// Consumers: entry_wise_accum, entry_accum_lane, entry_wise_mean.
package cfa_pkg;

    localparam int ENTRY_CNT = 5;
    localparam int PIX_W     = 12;
    localparam int SUM_W     = 16;

    // Smallest sum width that holds n full-scale samples of in_w bits.
    function automatic int sum_w_min(input int n, input int in_w);
        return in_w + $clog2(n);
    endfunction

endpackage

// File: rtl/entry_accum_lane.sv
// One lane: running accumulator plus the registered group sum.
// Latency: e updates on the edge that asserts load_out.
// Backpressure: none locally; the top gates load_acc/load_out.
module entry_accum_lane #(
    parameter int IN_W  = 12,
    parameter int SUM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  x,
    input  logic             first,
    input  logic             load_acc,
    input  logic             load_out,
    output logic [SUM_W-1:0] e
);

    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] acc_base;
    logic [SUM_W-1:0] acc_sum;
    logic [SUM_W-1:0] out_q;

    // The first beat of a group restarts from zero, so the previous group's
    // leftover accumulator value never needs an explicit clear.
    always_comb begin
        acc_base = first ? '0 : acc;
        acc_sum  = acc_base + SUM_W'(x);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc   <= '0;
            out_q <= '0;
        end else begin
            if (load_acc) begin
                acc <= acc_sum;
            end
            if (load_out) begin
                out_q <= acc + SUM_W'(x);
            end
        end
    end

    assign e = out_q;

endmodule

// File: rtl/entry_wise_accum.sv
// Sums each of five sample entries over groups of N accepted beats.
// Latency: sums and out_valid appear on the edge accepting the Nth beat.
// Backpressure: only the group-completing beat stalls while output is unacked.
module entry_wise_accum
    import cfa_pkg::*;
#(
    parameter int N     = 5,
    parameter int IN_W  = cfa_pkg::PIX_W,
    parameter int SUM_W = cfa_pkg::SUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [IN_W-1:0]  x1,
    input  logic [IN_W-1:0]  x2,
    input  logic [IN_W-1:0]  x3,
    input  logic [IN_W-1:0]  x4,
    input  logic [IN_W-1:0]  x5,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SUM_W-1:0] e1,
    output logic [SUM_W-1:0] e2,
    output logic [SUM_W-1:0] e3,
    output logic [SUM_W-1:0] e4,
    output logic [SUM_W-1:0] e5,
    output logic             out_valid,
    input  logic             out_ack
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if (N < 2 || SUM_W < sum_w_min(N, IN_W)) begin : g_bad_params
            $error("entry_wise_accum: N must be >= 2 and SUM_W >= IN_W + clog2(N)");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic             out_valid_q;
    logic             cnt_last;
    logic             stall;
    logic             accept;
    logic             first;
    logic             load_acc;
    logic             load_out;

    logic [IN_W-1:0]  x_arr [ENTRY_CNT];
    logic [SUM_W-1:0] e_arr [ENTRY_CNT];

    assign x_arr[0] = x1;
    assign x_arr[1] = x2;
    assign x_arr[2] = x3;
    assign x_arr[3] = x4;
    assign x_arr[4] = x5;

    // Accumulation of the next group proceeds under a held output; only the
    // beat that would overwrite the unacknowledged sums is refused.
    always_comb begin
        cnt_last = (cnt == CNT_LAST);
        stall    = cnt_last && out_valid_q && !out_ack;
        in_ready = rst && !clr && !stall;
        accept   = in_valid && in_ready;
        first    = (cnt == '0);
        load_acc = accept && !cnt_last;
        load_out = accept && cnt_last;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
            end

            // A completion in the ack cycle reloads, keeping out_valid high.
            if (load_out) begin
                out_valid_q <= 1'b1;
            end else if (out_ack) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < ENTRY_CNT; k++) begin : g_lane
        entry_accum_lane #(
            .IN_W  (IN_W),
            .SUM_W (SUM_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .x        (x_arr[k]),
            .first    (first),
            .load_acc (load_acc),
            .load_out (load_out),
            .e        (e_arr[k])
        );
    end

    assign e1        = e_arr[0];
    assign e2        = e_arr[1];
    assign e3        = e_arr[2];
    assign e4        = e_arr[3];
    assign e5        = e_arr[4];
    assign out_valid = out_valid_q;

endmodule
